// File: rtl/cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_capture_ctrl
// Description : Single-frame DVP capture sequencer; pairs RGB565 bytes into
//               cropped RGB444 pixels written in raster order to BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_capture_ctrl #(
    parameter int ADDR_W   = 17,
    parameter int FB_DEPTH = 76800
) (
    input  logic              cam_pclk,
    input  logic              sys_rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              axil_capture_start,
    input  logic [8:0]        axil_cap_width,
    input  logic [8:0]        axil_cap_height,
    output logic              axil_capture_done,
    output logic              axil_capture_busy,
    output logic [ADDR_W-1:0] cap_bram_waddr,
    output logic [11:0]       cap_bram_wdata,
    output logic              cap_bram_wen
);

    localparam logic [ADDR_W:0] c_fb_depth = (ADDR_W+1)'(FB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_vsync_d;
    logic              r_vsync_d2;
    logic              r_href_d;
    logic              r_href_d2;
    logic [7:0]        r_data_d;
    logic [8:0]        r_width;
    logic [8:0]        r_height;
    logic [ADDR_W-1:0] r_ptr;
    logic [8:0]        r_row;
    logic [8:0]        r_col;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic              r_wen;
    logic [ADDR_W-1:0] r_waddr;
    logic [11:0]       r_wdata;

    logic w_vsync_fall;
    logic w_vsync_rise;
    logic w_href_fall;
    logic w_start_ok;
    logic w_zero_size;
    logic w_last_row;
    logic w_store;

    assign w_vsync_fall = r_vsync_d2 & ~r_vsync_d;
    assign w_vsync_rise = ~r_vsync_d2 & r_vsync_d;
    assign w_href_fall  = r_href_d2 & ~r_href_d;
    assign w_start_ok   = axil_capture_start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_zero_size  = (axil_cap_width == 9'd0) | (axil_cap_height == 9'd0);
    assign w_last_row   = (({1'b0, r_row} + 10'd1) == {1'b0, r_height});
    assign w_store      = (r_state == S_CAPTURE) & r_href_d & r_phase
                        & (r_col < r_width) & (r_row < r_height)
                        & ({1'b0, r_ptr} < c_fb_depth);

    always_ff @(posedge cam_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_next = w_zero_size ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                if (w_vsync_fall) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // A short frame (vsync rising early) still counts as complete.
                if (w_vsync_rise || (w_href_fall && w_last_row)) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge cam_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            r_vsync_d  <= 1'b0;
            r_vsync_d2 <= 1'b0;
            r_href_d   <= 1'b0;
            r_href_d2  <= 1'b0;
            r_data_d   <= 8'd0;
            r_width    <= 9'd0;
            r_height   <= 9'd0;
            r_ptr      <= '0;
            r_row      <= 9'd0;
            r_col      <= 9'd0;
            r_phase    <= 1'b0;
            r_hi       <= 8'd0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= 12'd0;
        end else begin
            r_vsync_d  <= cam_vsync;
            r_vsync_d2 <= r_vsync_d;
            r_href_d   <= cam_href;
            r_href_d2  <= r_href_d;
            r_data_d   <= cam_data;
            r_wen      <= 1'b0;

            if (w_start_ok) begin
                r_width  <= axil_cap_width;
                r_height <= axil_cap_height;
                r_ptr    <= '0;
                r_row    <= 9'd0;
                r_col    <= 9'd0;
                r_phase  <= 1'b0;
            end else if (r_state == S_CAPTURE) begin
                if (r_href_d) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_hi <= r_data_d;
                    end else begin
                        if (r_col != 9'd511) begin
                            r_col <= r_col + 9'd1;
                        end
                        if (w_store) begin
                            r_wen   <= 1'b1;
                            r_waddr <= r_ptr;
                            r_wdata <= {r_hi[7:4], r_hi[2:0], r_data_d[7], r_data_d[4:1]};
                            r_ptr   <= r_ptr + ADDR_W'(1);
                        end
                    end
                end else if (w_href_fall) begin
                    // An odd trailing byte is dropped by resetting the phase here.
                    r_row   <= r_row + 9'd1;
                    r_col   <= 9'd0;
                    r_phase <= 1'b0;
                end
            end
        end
    end

    assign axil_capture_done = (r_state == S_DONE);
    assign axil_capture_busy = (r_state == S_ARM) | (r_state == S_CAPTURE);
    assign cap_bram_waddr    = r_waddr;
    assign cap_bram_wdata    = r_wdata;
    assign cap_bram_wen      = r_wen;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_capture_ctrl
// Description : Directed and randomized frames checked against a per-line
//               pixel model of the capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_capture_ctrl;

    localparam int TB_DEPTH = 40;

    logic        cam_pclk = 1'b0;
    logic        sys_rst;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        axil_capture_start;
    logic [8:0]  axil_cap_width;
    logic [8:0]  axil_cap_height;
    logic        axil_capture_done;
    logic        axil_capture_busy;
    logic [16:0] cap_bram_waddr;
    logic [11:0] cap_bram_wdata;
    logic        cap_bram_wen;

    cam_capture_ctrl #(.ADDR_W(17), .FB_DEPTH(TB_DEPTH)) dut (
        .cam_pclk           (cam_pclk),
        .sys_rst            (sys_rst),
        .cam_vsync          (cam_vsync),
        .cam_href           (cam_href),
        .cam_data           (cam_data),
        .axil_capture_start (axil_capture_start),
        .axil_cap_width     (axil_cap_width),
        .axil_cap_height    (axil_cap_height),
        .axil_capture_done  (axil_capture_done),
        .axil_capture_busy  (axil_capture_busy),
        .cap_bram_waddr     (cap_bram_waddr),
        .cap_bram_wdata     (cap_bram_wdata),
        .cap_bram_wen       (cap_bram_wen)
    );

    always #5 cam_pclk = ~cam_pclk;

    int cyc = 0;
    always @(posedge cam_pclk) cyc++;

    logic [16:0] got_addr[$];
    logic [11:0] got_data[$];
    int          got_cyc[$];
    logic [16:0] exp_addr[$];
    logic [11:0] exp_data[$];
    logic [7:0]  fix_bytes[$];

    always @(negedge cam_pclk) begin
        if (cap_bram_wen === 1'b1) begin
            got_addr.push_back(cap_bram_waddr);
            got_data.push_back(cap_bram_wdata);
            got_cyc.push_back(cyc);
        end
    end

    int tests = 0;
    int fails = 0;

    // Model of the frame: crop size, lines accepted so far, stored pixel count.
    int m_w, m_h, m_row, m_ptr;
    bit m_active;
    int last_lo_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pix(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] w;
        w = {hi, lo};
        return {w[15:12], w[10:7], w[4:1]};
    endfunction

    task automatic do_start(input int w, input int h);
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        exp_addr.delete(); exp_data.delete();
        @(negedge cam_pclk);
        axil_capture_start = 1'b1;
        axil_cap_width     = 9'(w);
        axil_cap_height    = 9'(h);
        @(negedge cam_pclk);
        axil_capture_start = 1'b0;
        m_w = w; m_h = h; m_row = 0; m_ptr = 0;
        m_active = (w != 0) && (h != 0);
    endtask

    task automatic frame_begin();
        @(negedge cam_pclk);
        cam_vsync = 1'b0;
        repeat (3) @(negedge cam_pclk);
    endtask

    task automatic frame_end();
        @(negedge cam_pclk);
        cam_vsync = 1'b1;
        m_active  = 1'b0;
        repeat (4) @(negedge cam_pclk);
    endtask

    task automatic send_line(input int nbytes, input int start_idx);
        logic [7:0] b;
        logic [7:0] hi;
        int c;
        c  = 0;
        hi = 8'd0;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge cam_pclk);
            if (fix_bytes.size() > 0) b = fix_bytes.pop_front();
            else b = 8'($urandom);
            cam_href = 1'b1;
            cam_data = b;
            axil_capture_start = (i == start_idx);
            if (i == start_idx) begin
                axil_cap_width  = 9'd1;
                axil_cap_height = 9'd1;
            end
            if (i % 2 == 0) begin
                hi = b;
            end else begin
                if (m_active && m_row < m_h && c < m_w && m_ptr < TB_DEPTH) begin
                    exp_addr.push_back(17'(m_ptr));
                    exp_data.push_back(pix(hi, b));
                    m_ptr++;
                end
                c++;
                last_lo_cyc = cyc;
            end
        end
        @(negedge cam_pclk);
        cam_href = 1'b0;
        axil_capture_start = 1'b0;
        cam_data = 8'($urandom);
        repeat (3) @(negedge cam_pclk);
        if (m_active) begin
            m_row++;
            if (m_row >= m_h) m_active = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input logic exp_done, input logic exp_busy);
        check({tag, " count"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check({tag, " addr"}, got_addr[i], exp_addr[i]);
            check({tag, " data"}, got_data[i], exp_data[i]);
        end
        if (exp_addr.size() > 0) begin
            check({tag, " addr hold"}, cap_bram_waddr, exp_addr[exp_addr.size()-1]);
            check({tag, " data hold"}, cap_bram_wdata, exp_data[exp_data.size()-1]);
        end
        check({tag, " done"}, axil_capture_done, exp_done);
        check({tag, " busy"}, axil_capture_busy, exp_busy);
        check({tag, " wen idle"}, cap_bram_wen, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst = 1'b1;
        cam_vsync = 1'b1;
        cam_href = 1'b0;
        cam_data = 8'd0;
        axil_capture_start = 1'b0;
        axil_cap_width = 9'd0;
        axil_cap_height = 9'd0;
        m_active = 1'b0;
        last_lo_cyc = 0;
        repeat (3) @(negedge cam_pclk);
        check("rst done", axil_capture_done, 1'b0);
        check("rst busy", axil_capture_busy, 1'b0);
        check("rst wen", cap_bram_wen, 1'b0);
        check("rst waddr", cap_bram_waddr, 17'd0);
        check("rst wdata", cap_bram_wdata, 12'd0);
        sys_rst = 1'b0;
        repeat (2) @(negedge cam_pclk);

        // 4x2 crop, two full lines
        do_start(4, 2);
        check("arm busy", axil_capture_busy, 1'b1);
        frame_begin();
        send_line(8, -1);
        check("mid done", axil_capture_done, 1'b0);
        send_line(8, -1);
        check_frame("w4h2", 1'b1, 1'b0);
        frame_end();

        // crop narrower than the line
        do_start(2, 1);
        frame_begin();
        send_line(8, -1);
        check_frame("w2h1", 1'b1, 1'b0);
        frame_end();

        // colour packing and write latency
        do_start(1, 1);
        frame_begin();
        fix_bytes.push_back(8'hF8);
        fix_bytes.push_back(8'h1F);
        send_line(2, -1);
        check("pix F0F", got_data.size() > 0 ? 32'(got_data[0]) : 32'hFFFF_FFFF, 32'hF0F);
        check("latency", got_cyc.size() > 0 ? got_cyc[0] : -1, last_lo_cyc + 2);
        check_frame("fixed", 1'b1, 1'b0);
        frame_end();

        // start ignored mid-capture, short frame ends on vsync rise
        do_start(4, 3);
        frame_begin();
        check("cap busy", axil_capture_busy, 1'b1);
        send_line(8, 3);
        check("short busy", axil_capture_busy, 1'b1);
        frame_end();
        check_frame("short", 1'b1, 1'b0);

        // zero width completes immediately
        do_start(0, 3);
        check("w0 done", axil_capture_done, 1'b1);
        frame_begin();
        send_line(8, -1);
        frame_end();
        check_frame("w0", 1'b1, 1'b0);

        // odd-length line drops its trailing byte
        do_start(4, 1);
        frame_begin();
        send_line(5, -1);
        check_frame("odd", 1'b1, 1'b0);
        frame_end();

        // frame larger than the buffer depth
        do_start(10, 5);
        frame_begin();
        for (int l = 0; l < 5; l++) send_line(20, -1);
        check_frame("depth", 1'b1, 1'b0);
        frame_end();

        // reset in the gap between lines of a capture
        do_start(4, 2);
        frame_begin();
        send_line(8, -1);
        @(negedge cam_pclk);
        sys_rst = 1'b1;
        #1;
        check("mrst busy", axil_capture_busy, 1'b0);
        check("mrst done", axil_capture_done, 1'b0);
        check("mrst wen", cap_bram_wen, 1'b0);
        check("mrst waddr", cap_bram_waddr, 17'd0);
        @(negedge cam_pclk);
        sys_rst = 1'b0;
        m_active = 1'b0;
        send_line(8, -1);
        check("mrst count", got_addr.size(), exp_addr.size());
        check("mrst done2", axil_capture_done, 1'b0);
        check("mrst idle", axil_capture_busy, 1'b0);
        frame_end();

        // randomized crops and line lengths
        for (int t = 0; t < 6; t++) begin
            int w, h, nl;
            w  = $urandom_range(1, 8);
            h  = $urandom_range(1, 4);
            nl = h + $urandom_range(0, 1);
            do_start(w, h);
            frame_begin();
            for (int l = 0; l < nl; l++) send_line(2 * w + $urandom_range(0, 5), -1);
            frame_end();
            check_frame("rand", 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
